// File: rtl/branch_predict_table.sv
// Direct-mapped table of 2-bit saturating branch counters indexed by PC, with a
// one-cycle registered lookup, resolve-time training and a misprediction tally.
module branch_predict_table #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 predict_valid,
  output logic                 predict_taken,
  output logic [1:0]           predict_state,
  input  logic                 update_valid,
  input  logic [PC_WIDTH-1:0]  update_pc,
  input  logic                 update_taken,
  input  logic                 update_predicted_taken,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            cnt_table [ENTRIES];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [1:0]            update_next;
  logic [1:0]            lookup_val;
  logic                  unused_pc_bits;

  function automatic logic [1:0] train(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign lookup_idx  = lookup_pc[INDEX_BITS+1:2];
  assign update_idx  = update_pc[INDEX_BITS+1:2];
  assign update_next = train(cnt_table[update_idx], update_taken);

  // Write-through: a same-cycle update to the looked-up entry is visible to the lookup.
  assign lookup_val = (update_valid && (update_idx == lookup_idx)) ? update_next
                                                                   : cnt_table[lookup_idx];

  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                            update_pc[PC_WIDTH-1:INDEX_BITS+2], update_pc[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) cnt_table[i] <= 2'b01;
    end else if (update_valid) begin
      cnt_table[update_idx] <= update_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      predict_valid <= 1'b0;
      predict_taken <= 1'b0;
      predict_state <= 2'b00;
    end else begin
      predict_valid <= lookup_valid;
      if (lookup_valid) begin
        predict_state <= lookup_val;
        predict_taken <= lookup_val[1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (update_valid && (update_taken != update_predicted_taken)
                 && !(&mispredict_count)) begin
      mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table: a default instance plus a CNT_WIDTH=4
// instance sharing the same stimulus to exercise misprediction saturation.
module tb_branch_predict_table;

  logic        clock = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_predicted_taken;

  logic        predict_valid, predict_taken;
  logic [1:0]  predict_state;
  logic [15:0] mispredict_count;

  logic        predict_valid_4, predict_taken_4;
  logic [1:0]  predict_state_4;
  logic [3:0]  mispredict_count_4;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  branch_predict_table dut (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(predict_valid), .predict_taken(predict_taken),
    .predict_state(predict_state),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_predicted_taken(update_predicted_taken),
    .mispredict_count(mispredict_count)
  );

  branch_predict_table #(.CNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(predict_valid_4), .predict_taken(predict_taken_4),
    .predict_state(predict_state_4),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_predicted_taken(update_predicted_taken),
    .mispredict_count(mispredict_count_4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic pred);
    update_valid = 1'b1; update_pc = pc;
    update_taken = taken; update_predicted_taken = pred;
    step();
    update_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1; lookup_pc = pc;
    step();
    lookup_valid = 1'b0;
  endtask

  task automatic check_pred(input string tag, input logic [1:0] st);
    check({tag, "_valid"}, {31'b0, predict_valid}, 32'd1);
    check({tag, "_state"}, {30'b0, predict_state}, {30'b0, st});
    check({tag, "_taken"}, {31'b0, predict_taken}, {31'b0, st[1]});
  endtask

  initial begin
    reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_predicted_taken = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_valid", {31'b0, predict_valid}, 32'd0);
    check("rst_state", {30'b0, predict_state}, 32'd0);
    check("rst_taken", {31'b0, predict_taken}, 32'd0);
    check("rst_count", {16'b0, mispredict_count}, 32'd0);

    do_lookup(32'h40);
    check_pred("init_40", 2'b01);

    // 01 -> 10 -> 11 -> 11; first update is a mispredict
    do_update(32'h40, 1'b1, 1'b0);
    do_update(32'h40, 1'b1, 1'b1);
    do_update(32'h40, 1'b1, 1'b1);
    do_lookup(32'h40);
    check_pred("sat_hi", 2'b11);
    step();
    check("idle_valid", {31'b0, predict_valid}, 32'd0);
    check("idle_hold", {30'b0, predict_state}, 32'd3);

    // 11 -> 10 -> 01, both mispredicts
    do_update(32'h40, 1'b0, 1'b1);
    do_update(32'h40, 1'b0, 1'b1);
    do_lookup(32'h40);
    check_pred("down_01", 2'b01);
    check("count_3", {16'b0, mispredict_count}, 32'd3);

    // Different index in the same cycle: no bypass (0x84 goes 01 -> 10)
    lookup_valid = 1'b1; lookup_pc = 32'h80;
    update_valid = 1'b1; update_pc = 32'h84; update_taken = 1'b1; update_predicted_taken = 1'b1;
    step();
    lookup_valid = 1'b0; update_valid = 1'b0;
    check_pred("nobyp", 2'b01);

    // Same index: prediction sees the trained value
    lookup_valid = 1'b1; lookup_pc = 32'h80;
    update_valid = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_predicted_taken = 1'b1;
    step();
    lookup_valid = 1'b0; update_valid = 1'b0;
    check_pred("bypass", 2'b10);

    do_lookup(32'h84);
    check_pred("nb_84", 2'b10);

    // 0x000 and 0x100 share index 0
    do_update(32'h000, 1'b1, 1'b1);
    do_update(32'h000, 1'b1, 1'b1);
    do_lookup(32'h100);
    check_pred("alias", 2'b11);

    // 5 mispredicts + 3 matching on top of the existing 3
    for (int i = 0; i < 5; i++) do_update(32'h3fc, i[0], ~i[0]);
    for (int i = 0; i < 3; i++) do_update(32'h3fc, i[0], i[0]);
    check("count_8", {16'b0, mispredict_count}, 32'd8);
    check("count4_8", {28'b0, mispredict_count_4}, 32'd8);

    for (int i = 0; i < 20; i++) do_update(32'h3f8, 1'b1, 1'b0);
    check("count_28", {16'b0, mispredict_count}, 32'd28);
    check("count4_sat", {28'b0, mispredict_count_4}, 32'd15);
    do_update(32'h3f8, 1'b0, 1'b1);
    check("count4_hold", {28'b0, mispredict_count_4}, 32'd15);
    check("count_29", {16'b0, mispredict_count}, 32'd29);

    // Reset mid-stream with a lookup in flight
    do_update(32'h40, 1'b1, 1'b1);
    do_update(32'h40, 1'b1, 1'b1);
    do_lookup(32'h40);
    check_pred("pre_rst", 2'b11);
    reset = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h40;
    update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b0; update_predicted_taken = 1'b1;
    step();
    reset = 1'b0; lookup_valid = 1'b0; update_valid = 1'b0;
    check("rst_drop_valid", {31'b0, predict_valid}, 32'd0);
    step();
    check("post_rst_valid", {31'b0, predict_valid}, 32'd0);
    do_lookup(32'h40);
    check_pred("post_rst", 2'b01);
    check("post_rst_count", {16'b0, mispredict_count}, 32'd0);
    check("post_rst_count4", {28'b0, mispredict_count_4}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_table.md
Name: branch_predict_table

Overview:
- Lookup side of the 2-bit saturating branch predictor. Holds a direct-mapped table of 2-bit counters indexed by PC.
- Fetch presents a PC and receives a registered taken/not-taken prediction one cycle later.
- The resolve stage returns the actual outcome, which trains the matching counter and updates a misprediction statistic.
- Sits between fetch (lookup) and branch resolution/CDB (update).

Parameters:
INDEX_BITS, 6, log2 of table entries (64 counters)
PC_WIDTH, 32, width of PC inputs
CNT_WIDTH, 16, width of misprediction counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
lookup_valid  in  1  fetch requests a prediction this cycle
lookup_pc  in  PC_WIDTH  PC of the branch being fetched
predict_valid  out  1  prediction valid (one cycle after lookup_valid)
predict_taken  out  1  predicted direction: counter MSB
predict_state  out  2  counter value used for the prediction
update_valid  in  1  a branch resolved this cycle
update_pc  in  PC_WIDTH  PC of the resolved branch
update_taken  in  1  actual outcome: 1 = taken, 0 = not taken
update_predicted_taken  in  1  direction that was predicted for this branch
mispredict_count  out  CNT_WIDTH  saturating count of resolved mispredictions

Behaviour:
- Clock and reset: single clock domain; all state changes on the rising edge of clock. Reset is synchronous and active-high.
- Reset values:
  - every table entry = 2'b01 (weakly not taken)
  - predict_valid = 0, predict_taken = 0, predict_state = 2'b00
  - mispredict_count = 0
  - reset has priority over any concurrent lookup or update; a lookup or update in a reset cycle is dropped.
- Index: idx = pc[INDEX_BITS+1:2]; PC bits [1:0] are ignored. There is no tag, so aliasing is permitted.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Update rule, applied at the edge when update_valid = 1:
  - taken: 00->01, 01->10, 10->11, 11->11 (saturates)
  - not taken: 11->10, 10->01, 01->00, 00->00 (saturates)
  - only the indexed entry changes; all other entries hold.
- Lookup:
  - latency exactly 1 cycle; no stall, so lookups may issue back-to-back every cycle.
  - at the edge where lookup_valid = 1:
    - predict_valid <= 1
    - predict_state <= counter[idx]
    - predict_taken <= counter[idx][1]
  - at the edge where lookup_valid = 0: predict_valid <= 0, and predict_taken/predict_state hold their last values.
- Same-cycle lookup and update to the same index: the prediction uses the post-update counter value (write-through bypass). Different indices are independent.
- Misprediction counter: when update_valid = 1 and update_taken != update_predicted_taken, mispredict_count increments by 1. It saturates at all-ones and never wraps.
- Interface rules:
  - no backpressure on either port.
  - at most one update per cycle; the resolve stage serialises updates.
  - update_pc for an unpredicted PC is legal and trains that entry normally.
- Reset mid-operation: a lookup in flight when reset asserts produces no predict_valid pulse; the cycle after reset deasserts shows predict_valid = 0.

Test Plan:
- Reset, then lookup PC 0x40 -> next cycle predict_valid = 1, predict_state = 01, predict_taken = 0; mispredict_count = 0.
- Three updates, taken, to PC 0x40, then lookup 0x40 -> states step 01->10->11->11 (saturates); prediction = 11, taken = 1. Then two not-taken updates -> lookup returns 01, taken = 0.
- Same cycle: lookup_pc = 0x80 and update_pc = 0x80, taken, with the entry at 01 -> predict_state = 10, predict_taken = 1 (bypass). Repeat with update_pc = 0x84 -> lookup of 0x80 returns 01.
- Aliasing, INDEX_BITS = 6: update PC 0x000 taken twice, then lookup PC 0x100 -> same index, returns 11.
- Misprediction count: 5 updates with update_taken != update_predicted_taken plus 3 matching -> mispredict_count = 5. Preload near saturation with CNT_WIDTH = 4: after 20 mispredicts the count reads 15 and holds.
- Reset mid-stream: train entry 0x40 to 11, assert reset for 1 cycle with lookup_valid = 1 -> predict_valid = 0 after reset; a subsequent lookup of 0x40 returns 01 and mispredict_count = 0.
